// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and default widths for the boot/run sequencer
package boot_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int CNT_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } boot_state_e;

endpackage

// File: rtl/boot_dump_seq.sv
// rtl/boot_dump_seq.sv - register-file dump address stepper with registered dump outputs
module boot_dump_seq
    import boot_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [REG_AW-1:0] rf_raddr_o,
    output logic              dump_valid_o,
    output logic [REG_AW-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              last_o
);

    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

    logic              active_q;
    logic [REG_AW-1:0] raddr_q;
    logic              valid_q;
    logic [REG_AW-1:0] idx_q;
    logic [DATA_W-1:0] data_q;

    // The read is combinational, so each issued address is captured on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            raddr_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            valid_q <= active_q;
            if (active_q) begin
                idx_q  <= raddr_q;
                data_q <= rf_rdata_i;
                if (raddr_q == LAST_IDX) begin
                    active_q <= 1'b0;
                end else begin
                    raddr_q <= raddr_q + 1'b1;
                end
            end
            if (start_i) begin
                active_q <= 1'b1;
                raddr_q  <= '0;
            end
        end
    end

    assign rf_raddr_o   = raddr_q;
    assign dump_valid_o = valid_q;
    assign dump_idx_o   = idx_q;
    assign dump_data_o  = data_q;
    assign last_o       = active_q && (raddr_q == LAST_IDX);

endmodule

// File: rtl/boot_run_ctrl.sv
// rtl/boot_run_ctrl.sv - program load, CPU reset hold, watchdogged run and register dump
module boot_run_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = DEF_REG_AW,
    parameter int RST_HOLD    = 2,
    parameter int CYCLE_LIMIT = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst_n,
    output logic              cpu_stall,
    input  logic              halt,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    output logic [REG_AW-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLE_LIMIT - 1);

    boot_state_e       state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [ADDR_W:0]   word_cnt_d;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic              ld_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [DATA_W-1:0] im_wdata_q;
    logic              cpu_rst_n_q;
    logic              cpu_stall_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic              run_end;
    logic              dump_last;

    // The counter is one bit wider than the address so a full-memory load
    // terminates before the address field wraps back to 0.
    assign word_cnt_d = word_cnt_q + 1'b1;
    assign run_end    = (state_q == ST_RUN) && (halt || (cycle_cnt_q == LIMIT_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            ld_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            cpu_stall_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_DONE) begin
                        done_q <= 1'b1;
                    end
                    if (start) begin
                        len_q       <= prog_len;
                        word_cnt_q  <= '0;
                        hold_cnt_q  <= '0;
                        cycle_cnt_q <= '0;
                        timeout_q   <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        cpu_stall_q <= 1'b0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        if (prog_len == '0) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q    <= ST_LOAD;
                            ld_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_valid && ld_ready_q) begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        im_wdata_q <= ld_data;
                        word_cnt_q <= word_cnt_d;
                        if (word_cnt_d == len_q) begin
                            ld_ready_q <= 1'b0;
                            hold_cnt_q <= '0;
                            state_q    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        cpu_rst_n_q <= 1'b1;
                        cycle_cnt_q <= '0;
                        state_q     <= ST_RUN;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // The count freezes on the exit cycle; halt overrides the watchdog.
                    if (run_end) begin
                        timeout_q   <= ~halt;
                        cpu_stall_q <= 1'b1;
                        state_q     <= ST_DUMP;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (dump_last) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    boot_dump_seq #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_dump_seq (
        .clk          (clk),
        .rst_n        (rst),
        .start_i      (run_end),
        .rf_rdata_i   (rf_rdata),
        .rf_raddr_o   (rf_raddr),
        .dump_valid_o (dump_valid),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .last_o       (dump_last)
    );

    assign ld_ready  = ld_ready_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign cpu_stall = cpu_stall_q;
    assign cycle_cnt = cycle_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// tb/tb_boot_run_ctrl.sv - scoreboard bench for boot_run_ctrl
module tb_boot_run_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              cpu_rst_n;
    logic              cpu_stall;
    logic              halt = 1'b0;
    logic [REG_AW-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              dump_valid;
    logic [REG_AW-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic [31:0]       cycle_cnt;
    logic              busy;
    logic              done;
    logic              timeout;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;
    typedef struct {
        logic [REG_AW-1:0] idx;
        logic [DATA_W-1:0] data;
    } dp_t;

    wr_t wq[$];
    dp_t dq[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    assign rf_rdata = DATA_W'(rf_raddr) * 32'd3;

    boot_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(32), .REG_AW(REG_AW),
        .RST_HOLD(2), .CYCLE_LIMIT(500)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst_n(cpu_rst_n), .cpu_stall(cpu_stall), .halt(halt),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .cycle_cnt(cycle_cnt), .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a dump pulse.
    logic prev_dv = 1'b0;
    logic exp_done_next = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_done_next) begin
                check("done_after_last_dump", done, 1);
                exp_done_next = 1'b0;
            end
            if (im_we) begin
                if (wq.size() == 0) begin
                    check("im_we_unexpected", im_we, 0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("im_addr", im_addr, w.addr);
                    check("im_wdata", im_wdata, w.data);
                end
            end
            if (dump_valid) begin
                if (dq.size() == 0) begin
                    check("dump_unexpected", dump_valid, 0);
                end else begin
                    dp_t d;
                    d = dq.pop_front();
                    check("dump_idx", dump_idx, d.idx);
                    check("dump_data", dump_data, d.data);
                    if (d.idx != 0) check("dump_contiguous", prev_dv, 1);
                    if (d.idx == 31) begin
                        check("done_low_at_last_dump", done, 0);
                        exp_done_next = 1'b1;
                    end
                end
            end
            prev_dv = dump_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        prog_len = (ADDR_W+1)'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        int n = 0;
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
        ld_valid = 1'b1;
        ld_data = d;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        check("ld_ready_seen", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        check("im_we_latency", im_we, 1);
    endtask

    task automatic push_dump();
        for (int i = 0; i < 32; i++) begin
            dp_t d;
            d.idx = REG_AW'(i);
            d.data = DATA_W'(i * 3);
            dq.push_back(d);
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (!cpu_rst_n && n < 50) begin
            tick();
            n++;
        end
        check("run_reached", cpu_rst_n, 1);
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (cycle_cnt != 32'(target) && n < 600) begin
            tick();
            n++;
        end
        check("cycle_cnt_reached", cycle_cnt, 64'(target));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 700) begin
            tick();
            n++;
        end
        check("done_reached", done, 1);
        check("busy_in_done", busy, 0);
        check("stall_in_done", cpu_stall, 1);
        check("dump_queue_empty", 64'(dq.size()), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_timeout", timeout, 0);
        check("rst_stall", cpu_stall, 0);
        rst = 1'b1;
        tick();

        // Load 4 words with a gap after word 1, then hold for 2 cycles
        do_start(4);
        check("load_ld_ready", ld_ready, 1);
        check("load_busy", busy, 1);
        send_word(32'hA0, 10'd0);
        send_word(32'hA1, 10'd1);
        tick();
        check("gap_no_write", im_we, 0);
        send_word(32'hA2, 10'd2);
        send_word(32'hA3, 10'd3);
        check("hold1_cpu_rst_n", cpu_rst_n, 0);
        check("hold1_ld_ready", ld_ready, 0);
        tick();
        check("hold2_cpu_rst_n", cpu_rst_n, 0);
        tick();
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_stall", cpu_stall, 0);
        check("run_cycle_cnt0", cycle_cnt, 0);

        // Halt in RUN cycle 37
        push_dump();
        wait_cnt(37);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt37_cycle_cnt", cycle_cnt, 37);
        check("halt37_timeout", timeout, 0);
        check("dump_stall", cpu_stall, 1);
        check("dump_cpu_rst_n", cpu_rst_n, 1);
        wait_done();
        check("writes_empty", 64'(wq.size()), 0);

        // Restart from DONE; start during RUN and DUMP is ignored; halt on the limit cycle
        do_start(2);
        check("restart_cycle_cnt", cycle_cnt, 0);
        check("restart_ld_ready", ld_ready, 1);
        check("restart_done", done, 0);
        send_word(32'h1234_5678, 10'd0);
        send_word(32'hDEAD_BEEF, 10'd1);
        wait_run();
        wait_cnt(10);
        do_start(5);
        check("run_start_ignored_rst", cpu_rst_n, 1);
        check("run_start_ignored_ready", ld_ready, 0);
        check("run_start_ignored_cnt", cycle_cnt, 11);
        push_dump();
        wait_cnt(499);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_at_limit_timeout", timeout, 0);
        check("halt_at_limit_cycle_cnt", cycle_cnt, 499);
        tick();
        tick();
        tick();
        do_start(3);
        check("dump_start_ignored_ready", ld_ready, 0);
        check("dump_start_ignored_stall", cpu_stall, 1);
        wait_done();

        // Watchdog expiry with prog_len=0
        do_start(0);
        check("len0_ld_ready", ld_ready, 0);
        push_dump();
        wait_run();
        wait_done();
        check("watchdog_timeout", timeout, 1);
        check("watchdog_cycle_cnt", cycle_cnt, 499);

        // Start in DONE clears timeout; reset mid-load aborts
        do_start(8);
        check("restart_timeout_clear", timeout, 0);
        check("restart2_cycle_cnt", cycle_cnt, 0);
        send_word(32'hB0, 10'd0);
        send_word(32'hB1, 10'd1);
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_cpu_rst_n", cpu_rst_n, 0);
        check("async_rst_ld_ready", ld_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_im_we", im_we, 0);
        check("async_rst_stall", cpu_stall, 0);
        check("async_rst_writes_done", 64'(wq.size()), 0);
        tick();
        rst = 1'b1;
        tick();

        // prog_len=0 goes straight to HOLD without any write
        do_start(0);
        check("len0b_ld_ready", ld_ready, 0);
        check("len0b_busy", busy, 1);
        check("len0b_hold_rst", cpu_rst_n, 0);
        tick();
        check("len0b_hold2_rst", cpu_rst_n, 0);
        tick();
        check("len0b_run_rst", cpu_rst_n, 1);
        push_dump();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt0_cycle_cnt", cycle_cnt, 0);
        wait_done();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
